// File: rtl/mips_defs.sv
// mips_defs: shared widths, opcodes, reset PC and fetch FSM encoding
package mips_defs;
    localparam int INSTR_W = 32;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} fetch_state_e;
endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with +4 increment and aligned branch redirect
module pc_register
    import mips_defs::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               branch_taken,
    input  logic [INSTR_W-1:0] branch_target,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus4
);
    logic [INSTR_W-1:0] pc_q, pc_d;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = load ? (branch_taken ? {branch_target[INSTR_W-1:2], 2'b00} : pc_plus4) : pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: request/ack instruction fetch, instruction register and consume counter
module fetch_unit
    import mips_defs::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [INSTR_W-1:0] branch_target,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic [INSTR_W-1:0] pc,
    output logic [INSTR_W-1:0] pc_plus4,
    output logic [31:0]        fetch_count
);
    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        count_q, count_d;
    logic               consume;

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (consume),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4)
    );

    // Clearing instr on consume keeps opcode/funct at zero whenever nothing is valid.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        count_d = count_q;
        consume = 1'b0;
        if (state_q == FETCH && imem_ack) begin
            instr_d = imem_rdata;
            state_d = HOLD;
        end
        if (state_q == HOLD && !stall) begin
            consume = 1'b1;
            instr_d = '0;
            count_d = count_q + 32'd1;
            state_d = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_valid = (state_q == HOLD);
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign fetch_count = count_q;
endmodule
